// File: rtl/uart_key_injector_pkg.sv
// Shared constants, state encodings and the ASCII-to-HID mapping used by the
// UART key injector.
package uart_key_injector_pkg;

  localparam logic [1:0] USB_TYPE_NONE = 2'd0;
  localparam logic [1:0] USB_TYPE_KBD  = 2'd1;

  localparam logic [7:0] MOD_NONE   = 8'h00;
  localparam logic [7:0] MOD_LSHIFT = 8'h02;

  localparam logic [7:0] SC_A     = 8'h04;
  localparam logic [7:0] SC_1     = 8'h1E;
  localparam logic [7:0] SC_0     = 8'h27;
  localparam logic [7:0] SC_ENTER = 8'h28;
  localparam logic [7:0] SC_BKSP  = 8'h2A;
  localparam logic [7:0] SC_SPACE = 8'h2C;
  localparam logic [7:0] SC_MINUS = 8'h2D;
  localparam logic [7:0] SC_COMMA = 8'h36;
  localparam logic [7:0] SC_DOT   = 8'h37;
  localparam logic [7:0] SC_SLASH = 8'h38;

  typedef enum logic [2:0] {
    RPT_IDLE,
    RPT_POP,
    RPT_PRESS,
    RPT_HOLD,
    RPT_RELEASE,
    RPT_GAP
  } rpt_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] mods;
    logic [7:0] code;
  } key_map_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Unmapped bytes come back with valid = 0 and are silently discarded.
  function automatic key_map_t ascii2scancode(input logic [7:0] ch);
    key_map_t m;
    m = '0;
    if (ch >= 8'h61 && ch <= 8'h7A) begin
      m = {1'b1, MOD_NONE, 8'(SC_A + (ch - 8'h61))};
    end else if (ch >= 8'h41 && ch <= 8'h5A) begin
      m = {1'b1, MOD_LSHIFT, 8'(SC_A + (ch - 8'h41))};
    end else if (ch >= 8'h31 && ch <= 8'h39) begin
      m = {1'b1, MOD_NONE, 8'(SC_1 + (ch - 8'h31))};
    end else begin
      case (ch)
        8'h30:        m = {1'b1, MOD_NONE, SC_0};
        8'h0D, 8'h0A: m = {1'b1, MOD_NONE, SC_ENTER};
        8'h08:        m = {1'b1, MOD_NONE, SC_BKSP};
        8'h20:        m = {1'b1, MOD_NONE, SC_SPACE};
        8'h2D:        m = {1'b1, MOD_NONE, SC_MINUS};
        8'h2C:        m = {1'b1, MOD_NONE, SC_COMMA};
        8'h2E:        m = {1'b1, MOD_NONE, SC_DOT};
        8'h2F:        m = {1'b1, MOD_NONE, SC_SLASH};
        default:      m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/uart_key_injector_if.sv
// HID keyboard report bundle, same field layout a USB HID host core drives.
interface uart_key_injector_if;
  logic [1:0] usb_type;
  logic       usb_report;
  logic [7:0] key_modifiers;
  logic [7:0] key1;
  logic [7:0] key2;
  logic [7:0] key3;
  logic [7:0] key4;

  modport master (
    output usb_type, usb_report, key_modifiers, key1, key2, key3, key4
  );

  modport slave (
    input usb_type, usb_report, key_modifiers, key1, key2, key3, key4
  );
endinterface

// File: rtl/uart_key_injector_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid or
// frame_err pulse per frame.
module uart_key_injector_rx
  import uart_key_injector_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);

  rx_state_t   state_reg, state_next;
  logic [1:0]  sync_reg;
  logic        prev_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]  bit_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  data_reg;
  logic        valid_reg, frame_err_reg;
  logic        rx_s, tick_half, tick_full, stop_ok, stop_bad;

  assign rx_s      = sync_reg[1];
  assign tick_half = (cnt_reg == HALF_LAST);
  assign tick_full = (cnt_reg == FULL_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= RX_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_IDLE:  if (prev_reg && !rx_s)           state_next = RX_START;
      RX_START: if (tick_half)                   state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_reg == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (tick_full)                   state_next = RX_IDLE;
      default:                                   state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    stop_ok  = (state_reg == RX_STOP) && tick_full && rx_s;
    stop_bad = (state_reg == RX_STOP) && tick_full && !rx_s;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_reg      <= 2'b11;
      prev_reg      <= 1'b1;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], rx};
      prev_reg <= rx_s;
      // Counter restarts at each sampling point so samples stay mid-bit.
      if (state_reg == RX_IDLE || (state_reg == RX_START && tick_half) || tick_full)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;
      if (state_reg == RX_START)
        bit_reg <= '0;
      else if (state_reg == RX_DATA && tick_full)
        bit_reg <= bit_reg + 1'b1;
      if (state_reg == RX_DATA && tick_full)
        shift_reg <= {rx_s, shift_reg[7:1]};
      if (stop_ok)
        data_reg <= shift_reg;
      valid_reg     <= stop_ok;
      frame_err_reg <= stop_bad;
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: rtl/uart_key_injector.sv
// Turns bytes received on a UART pin into HID keyboard press/release reports
// through a small byte FIFO and a report-pacing FSM.
module uart_key_injector
  import uart_key_injector_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CYC   = 120000,
  parameter int GAP_CYC    = 120000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 uart_rx,
  uart_key_injector_if.master  hid,
  output logic                 rx_overflow,
  output logic                 rx_frame_err
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(max3(DIV, HOLD_CYC, GAP_CYC) + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // HOLD lasts HOLD_CYC-1 cycles so the release strobe lands HOLD_CYC cycles after the press strobe.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0] rx_data;
  logic       rx_valid;

  uart_key_injector_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (uart_rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_frame_err)
  );

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             fifo_full, fifo_empty, push_ok, pop;
  logic             overflow_reg;
  key_map_t         pop_map;

  rpt_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       type_reg;
  logic [7:0]       key1_reg, mod_reg;
  logic             report, load_press, load_release;

  assign fifo_full  = (count_reg == FIFO_FULL);
  assign fifo_empty = (count_reg == '0);
  assign pop        = (state_reg == RPT_POP);
  // A pop in the same cycle frees a slot, so a push while full is still accepted.
  assign push_ok    = rx_valid && (!fifo_full || pop);
  assign pop_map    = ascii2scancode(fifo_mem[rd_ptr_reg]);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= rx_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      overflow_reg <= rx_valid && !push_ok;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= RPT_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RPT_IDLE:    if (!fifo_empty)         state_next = RPT_POP;
      RPT_POP:     state_next = pop_map.valid ? RPT_PRESS : RPT_IDLE;
      RPT_PRESS:   state_next = RPT_HOLD;
      RPT_HOLD:    if (cnt_reg == HOLD_LAST) state_next = RPT_RELEASE;
      RPT_RELEASE: state_next = RPT_GAP;
      RPT_GAP:     if (cnt_reg == GAP_LAST)  state_next = RPT_IDLE;
      default:     state_next = RPT_IDLE;
    endcase
  end

  always_comb begin
    report       = (state_reg == RPT_PRESS) || (state_reg == RPT_RELEASE);
    load_press   = (state_reg == RPT_POP) && pop_map.valid;
    load_release = (state_reg == RPT_HOLD) && (state_next == RPT_RELEASE);
  end

  // Field registers load on the edge entering PRESS/RELEASE, so they change together with the strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg  <= '0;
      type_reg <= USB_TYPE_NONE;
      key1_reg <= '0;
      mod_reg  <= MOD_NONE;
    end else begin
      if (state_next != state_reg)
        cnt_reg <= '0;
      else if (state_reg == RPT_HOLD || state_reg == RPT_GAP)
        cnt_reg <= cnt_reg + 1'b1;
      if (load_press) begin
        type_reg <= USB_TYPE_KBD;
        key1_reg <= pop_map.code;
        mod_reg  <= pop_map.mods;
      end else if (load_release) begin
        key1_reg <= '0;
        mod_reg  <= MOD_NONE;
      end
    end
  end

  assign hid.usb_type      = type_reg;
  assign hid.usb_report    = report;
  assign hid.key_modifiers = mod_reg;
  assign hid.key1          = key1_reg;
  assign hid.key2          = '0;
  assign hid.key3          = '0;
  assign hid.key4          = '0;
  assign rx_overflow       = overflow_reg;

endmodule
